// File: rtl/multi_flex_counter_pkg.sv
// Shared types for the multi-channel flex counter: per-channel state record and terminal selection.
// The optional down-count mode is enabled with the MULTI_FLEX_COUNTER_DOWN_EN macro.
package multi_flex_counter_pkg;

  // Widest supported channel; per-channel counts are zero-extended into this field.
  localparam int MAX_CNT_W = 32;

  typedef enum logic {
    TERM_ROLLOVER,
    TERM_ONE
  } term_sel_e;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] count;
    logic                 flag;
    logic                 pulse;
    logic                 done;
  } chan_state_t;

  function automatic term_sel_e term_sel(input logic down_en, input logic count_down);
    return (down_en && count_down) ? TERM_ONE : TERM_ROLLOVER;
  endfunction

endpackage

// File: rtl/flex_chan.sv
// One flex counter channel: clear > load > effective enable > hold, with carry out for cascading.
// Down counting (terminal value 1) exists only when MULTI_FLEX_COUNTER_DOWN_EN is defined.
module flex_chan
  import multi_flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic                    oneshot,
  input  logic                    count_down,
  input  logic                    carry_in,
  output logic                    carry_out,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    done
);

`ifdef MULTI_FLEX_COUNTER_DOWN_EN
  localparam logic DOWN_EN = 1'b1;
`else
  localparam logic DOWN_EN = 1'b0;
`endif
  localparam int MW = MAX_CNT_W;

  chan_state_t   state_q, state_d;
  logic [MW-1:0] roll_w, load_w, term_w, step_w;
  logic          en_eff, roll_ok, at_term, down_mode, lands;

  assign down_mode = (term_sel(DOWN_EN, count_down) == TERM_ONE);
  assign roll_w    = MW'(rollover_val);
  assign load_w    = MW'(load_val);
  assign term_w    = down_mode ? MW'(1) : roll_w;
  // A zero rollover value disables the channel's terminal entirely.
  assign roll_ok   = (roll_w != '0);
  assign at_term   = roll_ok && (state_q.count == term_w);
  assign en_eff    = count_enable && carry_in;
  assign carry_out = en_eff && at_term && !oneshot;
  assign lands     = (step_w == term_w);

  always_comb begin
    step_w = state_q.count + MW'(1);
    if (down_mode) begin
      step_w = (state_q.count <= MW'(1)) ? roll_w : state_q.count - MW'(1);
    end else if (state_q.count >= roll_w) begin
      step_w = MW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    state_d.pulse = 1'b0;
    if (clear) begin
      state_d = '0;
    end else if (load) begin
      state_d.count = load_w;
      state_d.flag  = roll_ok && (load_w == term_w);
      state_d.done  = 1'b0;
    end else if (en_eff) begin
      if (!roll_ok) begin
        state_d.flag = 1'b0;
      end else if (state_q.done || (oneshot && at_term)) begin
        // Oneshot parked at terminal: hold and ignore further enables.
        state_d.done = 1'b1;
      end else begin
        state_d.count = step_w;
        state_d.flag  = lands;
        state_d.pulse = lands;
        state_d.done  = oneshot && lands;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign count_out      = state_q.count[NUM_CNT_BITS-1:0];
  assign rollover_flag  = state_q.flag;
  assign rollover_pulse = state_q.pulse;
  assign done           = state_q.done;

endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flex counter channels, optionally cascaded through a same-cycle carry ripple.
// Define MULTI_FLEX_COUNTER_DOWN_EN to enable per-channel down counting via count_down.
module multi_flex_counter
  import multi_flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 4,
  parameter int CASCADE      = 0
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CH-1:0]              oneshot,
  input  logic [NUM_CH-1:0]              count_down,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic [NUM_CH-1:0]              done
);

  logic [NUM_CH-1:0] carry, carry_in;
  logic              unused_carry;

  // The last channel's carry (and all carries when not cascaded) has no consumer.
  assign unused_carry = ^carry;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (CASCADE != 0 && i > 0) begin : g_casc
      assign carry_in[i] = carry[(i > 0) ? i - 1 : 0];
    end else begin : g_free
      assign carry_in[i] = 1'b1;
    end

    flex_chan #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_chan (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear[i]),
      .count_enable  (count_enable[i]),
      .load          (load[i]),
      .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .oneshot       (oneshot[i]),
      .count_down    (count_down[i]),
      .carry_in      (carry_in[i]),
      .carry_out     (carry[i]),
      .count_out     (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag (rollover_flag[i]),
      .rollover_pulse(rollover_pulse[i]),
      .done          (done[i])
    );
  end

endmodule
